// File: rtl/csi2_pkg.sv
// Shared types and constants for the CSI-2 packet parser.
package csi2_pkg;

    // Parser states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_PAYLOAD,
        ST_DONE
    } state_t;

    // Data type codes
    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_RAW10    = 6'h2B;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    // Header ECC parity masks over {WC_H, WC_L, DI}; index k produces ECC bit k
    localparam logic [5:0][23:0] ECC_MASKS = {
        24'hEFFC00,  // P5
        24'hDF03F0,  // P4
        24'hB8E38E,  // P3
        24'h749A6D,  // P2
        24'hF2555B,  // P1
        24'hF12CB7   // P0
    };

endpackage

// File: rtl/csi2_ecc.sv
// Combinational CSI-2 header ECC generator; bits [7:6] are always zero.
module csi2_ecc
    import csi2_pkg::*;
(
    input  logic [23:0] hdr,
    output logic [7:0]  ecc
);

    // Each parity bit is the XOR of the header bits selected by its mask
    always_comb begin
        ecc = '0;
        for (int k = 0; k < 6; k++) begin
            ecc[k] = ^(hdr & ECC_MASKS[k]);
        end
    end

endmodule

// File: rtl/csi2_packet_parser.sv
// CSI-2 packet parser: sync check, header/ECC decode, sync pulses and payload stream.
module csi2_packet_parser
    import csi2_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE       = 8'hB8,
    parameter bit         ECC_CHECK       = 1'b1,
    parameter bit         DROP_ON_ECC_ERR = 1'b1
) (
    input  logic        byte_clk,
    input  logic        reset,
    input  logic        hs_active,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        frame_start,
    output logic        frame_end,
    output logic        line_start,
    output logic        line_end,
    output logic [1:0]  vc,
    output logic [5:0]  data_type,
    output logic [15:0] word_count,
    output logic        pay_valid,
    output logic [15:0] pay_data,
    output logic [1:0]  pay_be,
    output logic        pay_last,
    output logic        sync_err,
    output logic        ecc_err,
    output logic        trunc_err
);

    state_t      state;
    logic [7:0]  di_q;
    logic [7:0]  wc_lo_q;
    logic [15:0] remaining;

    // The second header word is decoded in the cycle it arrives, so the
    // word count and ECC are taken straight from in_data combined with the
    // bytes latched from the first header word.
    logic [15:0] hdr_wc;
    logic [5:0]  hdr_dt;
    logic [7:0]  ecc_calc;
    logic        ecc_bad;

    assign hdr_wc  = {in_data[7:0], wc_lo_q};
    assign hdr_dt  = di_q[5:0];
    assign ecc_bad = ECC_CHECK && (ecc_calc != in_data[15:8]);

    csi2_ecc u_ecc (
        .hdr ({in_data[7:0], wc_lo_q, di_q}),
        .ecc (ecc_calc)
    );

    // Main parser FSM with all outputs registered
    always_ff @(posedge byte_clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            di_q        <= '0;
            wc_lo_q     <= '0;
            remaining   <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            vc          <= '0;
            data_type   <= '0;
            word_count  <= '0;
            pay_valid   <= 1'b0;
            pay_data    <= '0;
            pay_be      <= '0;
            pay_last    <= 1'b0;
            sync_err    <= 1'b0;
            ecc_err     <= 1'b0;
            trunc_err   <= 1'b0;
        end else begin
            // Pulses default low; they are raised for one cycle below
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            pay_valid   <= 1'b0;
            pay_last    <= 1'b0;
            sync_err    <= 1'b0;
            ecc_err     <= 1'b0;
            trunc_err   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (in_valid && hs_active) begin
                        if (in_data == {SYNC_BYTE, SYNC_BYTE}) begin
                            state <= ST_HDR0;
                        end else begin
                            sync_err <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end

                ST_HDR0: begin
                    if (!hs_active) begin
                        trunc_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (in_valid) begin
                        di_q    <= in_data[7:0];
                        wc_lo_q <= in_data[15:8];
                        state   <= ST_HDR1;
                    end
                end

                ST_HDR1: begin
                    if (!hs_active) begin
                        trunc_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (in_valid) begin
                        ecc_err <= ecc_bad;
                        if (ecc_bad && DROP_ON_ECC_ERR) begin
                            state <= ST_DONE;
                        end else begin
                            vc         <= di_q[7:6];
                            data_type  <= hdr_dt;
                            word_count <= hdr_wc;
                            if (hdr_dt < DT_LONG_MIN) begin
                                frame_start <= (hdr_dt == DT_FS);
                                frame_end   <= (hdr_dt == DT_FE);
                                line_start  <= (hdr_dt == DT_LS);
                                line_end    <= (hdr_dt == DT_LE);
                                state       <= ST_DONE;
                            end else if (hdr_wc == 16'd0) begin
                                state <= ST_DONE;
                            end else begin
                                remaining <= hdr_wc;
                                state     <= ST_PAYLOAD;
                            end
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (!hs_active) begin
                        trunc_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (in_valid) begin
                        pay_valid <= 1'b1;
                        pay_data  <= in_data;
                        if (remaining >= 16'd2) begin
                            pay_be    <= 2'b11;
                            remaining <= remaining - 16'd2;
                        end else begin
                            // Odd tail byte; count saturates at zero
                            pay_be    <= 2'b01;
                            remaining <= '0;
                        end
                        if (remaining <= 16'd2) begin
                            pay_last <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    // Trailing CRC and anything else in the burst is dropped
                    if (!hs_active) state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
